// File: rtl/ssd1289_bus_writer.sv
// ssd1289_bus_writer: FIFO-buffered replay of {rs,data} words as 8080-style write cycles on the SSD1289 bus.
// Producer has no backpressure; words arriving while full are dropped and flagged in sticky overflow.
module ssd1289_bus_writer #(
    parameter int FIFO_AW     = 4,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               app_valid,
    input  logic [16:0]        app_din,
    input  logic               ovf_clr,
    output logic               lcd_cs_n,
    output logic               lcd_rs,
    output logic               lcd_wr_n,
    output logic               lcd_rd_n,
    output logic [15:0]        lcd_db,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_full,
    output logic               bus_idle,
    output logic               overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int MAXC  = WR_LOW_CYC > WR_HIGH_CYC ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LO_R = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] HI_R = CW'(WR_HIGH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRLO, S_WRHI} state_t;

    state_t             state, nxt;
    logic [16:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [CW-1:0]      cnt;
    logic               push, pop, empty;
    logic               cs_d, wr_d, rs_d;
    logic [15:0]        db_d;

    assign empty     = fifo_level == '0;
    assign fifo_full = fifo_level == (FIFO_AW + 1)'(DEPTH);
    assign push      = app_valid && !fifo_full;
    assign pop       = state == S_LOAD;
    assign bus_idle  = empty && state == S_IDLE;
    assign lcd_rd_n  = 1'b1;

    always_ff @(posedge sys_clk)
        if (push) mem[wp] <= app_din;

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            wp         <= push ? wp + 1'b1 : wp;
            rp         <= pop ? rp + 1'b1 : rp;
            fifo_level <= fifo_level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            overflow   <= (app_valid && fifo_full) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end

    // cnt reloads whenever the state changes, so each phase length is exact
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? (nxt == S_WRLO ? LO_R : HI_R) : cnt - CW'(1);
        end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = empty ? S_IDLE : S_LOAD;
            S_LOAD:  nxt = S_WRLO;
            S_WRLO:  nxt = cnt == '0 ? S_WRHI : S_WRLO;
            default: nxt = cnt != '0 ? S_WRHI : empty ? S_IDLE : S_LOAD;
        endcase
    end

    always_comb begin
        cs_d = state == S_IDLE;
        wr_d = state != S_WRLO;
        rs_d = pop ? mem[rp][16] : lcd_rs;
        db_d = pop ? mem[rp][15:0] : lcd_db;
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_db   <= '0;
        end else begin
            lcd_cs_n <= cs_d;
            lcd_wr_n <= wr_d;
            lcd_rs   <= rs_d;
            lcd_db   <= db_d;
        end
endmodule

// File: tb/tb_ssd1289_bus_writer.sv
// tb_ssd1289_bus_writer: directed bench for ssd1289_bus_writer with a word scoreboard checked on each wr_n rising edge.
module tb_ssd1289_bus_writer;
    logic        sys_clk = 1'b0, rst_n = 1'b0, app_valid = 1'b0, ovf_clr = 1'b0;
    logic [16:0] app_din = '0;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, fifo_full, bus_idle, overflow;
    logic [15:0] lcd_db;
    logic [4:0]  fifo_level;

    int          checks = 0, errors = 0;
    int          pulses = 0, wr_run = 0, cs_run = 0, last_cs_run = 0, max_level = 0;
    logic        prev_wr = 1'b1;
    logic [16:0] sb [$];

    ssd1289_bus_writer dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .app_valid(app_valid), .app_din(app_din),
        .ovf_clr(ovf_clr), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
        .lcd_rd_n(lcd_rd_n), .lcd_db(lcd_db), .fifo_level(fifo_level),
        .fifo_full(fifo_full), .bus_idle(bus_idle), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bus monitor: every wr_n rising edge retires the oldest expected word
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_wr = 1'b1;
            wr_run  = 0;
            cs_run  = 0;
        end else begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (!lcd_wr_n) wr_run++;
            if (lcd_wr_n && !prev_wr) begin
                logic [16:0] e;
                pulses++;
                check("wr_low_len", wr_run, 2);
                check("pulse_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pulse_word", {lcd_rs, lcd_db}, e);
                end
                wr_run = 0;
            end
            if (!lcd_cs_n) cs_run++;
            else if (cs_run > 0) begin
                last_cs_run = cs_run;
                cs_run      = 0;
            end
            prev_wr = lcd_wr_n;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [16:0] w, input bit acc);
        tick();
        app_valid = 1'b1;
        app_din   = w;
        if (acc) sb.push_back(w);
    endtask

    task automatic stop();
        tick();
        app_valid = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((!bus_idle || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
    endtask

    initial begin
        int p0;
        bit saw_full;
        logic [16:0] hdr [11];
        logic        cs_tab [7] = '{1, 0, 0, 0, 0, 0, 1};
        logic        wr_tab [7] = '{1, 1, 0, 0, 1, 1, 1};

        tick();
        check("rst_cs_n", lcd_cs_n, 1);
        check("rst_wr_n", lcd_wr_n, 1);
        check("rst_rd_n", lcd_rd_n, 1);
        check("rst_rs", lcd_rs, 1);
        check("rst_db", lcd_db, 0);
        check("rst_level", fifo_level, 0);
        check("rst_full", fifo_full, 0);
        check("rst_idle", bus_idle, 1);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // single word while idle: latency and pulse shape
        p0 = pulses;
        send({1'b0, 16'h0044}, 1);
        stop();
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t1_cs_k%0d", k + 1), lcd_cs_n, cs_tab[k]);
            check($sformatf("t1_wr_k%0d", k + 1), lcd_wr_n, wr_tab[k]);
            if (k == 1) check("t1_setup_word", {lcd_rs, lcd_db}, {1'b0, 16'h0044});
        end
        tick();
        check("t1_pulses", pulses - p0, 1);
        check("t1_cs_len", last_cs_run, 5);
        check("t1_idle", bus_idle, 1);

        // 11-word window header burst
        hdr = '{17'h00044, 17'h1EF00, 17'h00045, 17'h10000, 17'h00046, 17'h1013F,
                17'h0004E, 17'h10000, 17'h0004F, 17'h10000, 17'h00022};
        p0 = pulses;
        for (int i = 0; i < 11; i++) send(hdr[i], 1);
        stop();
        wait_drain(200);
        tick();
        check("t2_pulses", pulses - p0, 11);
        check("t2_cs_len", last_cs_run, 55);
        check("t2_ovf", overflow, 0);

        // paced data stream, one word every 5 clocks
        p0 = pulses;
        max_level = 0;
        for (int i = 0; i < 240; i++) begin
            send({1'b1, 16'(i * 16'd37 + 16'd5)}, 1);
            repeat (4) stop();
        end
        wait_drain(200);
        check("t3_pulses", pulses - p0, 240);
        check("t3_level_le2", max_level <= 2, 1);
        check("t3_ovf", overflow, 0);

        // 24-word overrun: words 20..22 hit a full FIFO, 23 finds a freed slot
        p0 = pulses;
        saw_full = 0;
        for (int i = 0; i < 24; i++) begin
            send({1'b1, 16'hA000 + 16'(i)}, i < 20 || i == 23);
            saw_full |= fifo_full;
        end
        stop();
        check("t4_saw_full", saw_full, 1);
        check("t4_ovf", overflow, 1);
        wait_drain(300);
        check("t4_pulses", pulses - p0, 21);

        // overflow clear, and set winning over a simultaneous clear
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_alone", overflow, 0);
        p0 = pulses;
        for (int i = 0; i < 21; i++) begin
            send({1'b0, 16'hB000 + 16'(i)}, i < 20);
            ovf_clr = i == 20;
        end
        stop();
        check("t5_set_wins", overflow, 1);
        wait_drain(300);
        check("t5_pulses", pulses - p0, 20);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_again", overflow, 0);

        // asynchronous reset during the wr_n low phase
        p0 = pulses;
        send({1'b1, 16'h1234}, 1);
        stop();
        repeat (3) tick();
        check("t6_in_wrlo", lcd_wr_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_wr", lcd_wr_n, 1);
        check("t6_async_cs", lcd_cs_n, 1);
        check("t6_async_level", fifo_level, 0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_no_pulse", pulses - p0, 0);
        check("t6_idle", bus_idle, 1);
        send({1'b0, 16'h0022}, 1);
        stop();
        wait_drain(100);
        check("t6_resume", pulses - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
